// File: rtl/alu_issue_stage_pkg.sv
// Shared constants for the ALU and the RV32I decode/issue stage.
package alu_issue_stage_pkg;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_SLL  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_SLT  = 5'd8,
    ALU_SLTU = 5'd9
  } alu_opc_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_opc_e    opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shft;
    logic [4:0]  rd;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        illegal;
  } dec_t;

  function automatic logic [31:0] sext12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Instruction handshake, regfile read port, ALU drive and writeback strobe.
interface alu_issue_stage_if;
  logic [31:0] INST;
  logic [31:0] INST_PC;
  logic        INST_VLD;
  logic        INST_RDY;
  logic [4:0]  RS1_ADDR;
  logic [4:0]  RS2_ADDR;
  logic [31:0] RS1_DATA;
  logic [31:0] RS2_DATA;
  logic        ALU_EN;
  logic [31:0] ALU_A;
  logic [31:0] ALU_B;
  logic [4:0]  ALU_OPC;
  logic [4:0]  ALU_SHFT;
  logic        ALU_CIN;
  logic        WB_EN;
  logic [4:0]  WB_ADDR;
  logic        ILLEGAL;
  logic [31:0] ILL_INST;

  modport slave (
    input  INST, INST_PC, INST_VLD, RS1_DATA, RS2_DATA,
    output INST_RDY, RS1_ADDR, RS2_ADDR, ALU_EN, ALU_A, ALU_B, ALU_OPC,
           ALU_SHFT, ALU_CIN, WB_EN, WB_ADDR, ILLEGAL, ILL_INST
  );

  modport master (
    output INST, INST_PC, INST_VLD, RS1_DATA, RS2_DATA,
    input  INST_RDY, RS1_ADDR, RS2_ADDR, ALU_EN, ALU_A, ALU_B, ALU_OPC,
           ALU_SHFT, ALU_CIN, WB_EN, WB_ADDR, ILLEGAL, ILL_INST
  );
endinterface

// File: rtl/alu_issue_stage_decode.sv
// Combinational RV32I decode for the ALU classes: OP, OP-IMM, LUI, AUIPC.
module rv32i_alu_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output dec_t        dec
);

  logic [2:0] f3;
  logic [6:0] f7;

  assign f3 = inst[14:12];
  assign f7 = inst[31:25];

  // decode opcode/funct fields into ALU controls; illegal words claim no sources
  always_comb begin
    dec.opc      = ALU_ADD;
    dec.a        = rs1_data;
    dec.b        = sext12(inst[31:20]);
    dec.shft     = inst[24:20];
    dec.rd       = inst[11:7];
    dec.uses_rs1 = 1'b0;
    dec.uses_rs2 = 1'b0;
    dec.illegal  = 1'b0;
    case (inst[6:0])
      OPC_OP: begin
        dec.uses_rs1 = 1'b1;
        dec.uses_rs2 = 1'b1;
        dec.b        = rs2_data;
        dec.shft     = rs2_data[4:0];
        if (f7 == F7_BASE) begin
          case (f3)
            3'b000:  dec.opc = ALU_ADD;
            3'b001:  dec.opc = ALU_SLL;
            3'b010:  dec.opc = ALU_SLT;
            3'b011:  dec.opc = ALU_SLTU;
            3'b100:  dec.opc = ALU_XOR;
            3'b101:  dec.opc = ALU_SRL;
            3'b110:  dec.opc = ALU_OR;
            default: dec.opc = ALU_AND;
          endcase
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          dec.opc = ALU_SUB;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          dec.opc = ALU_SRA;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec.uses_rs1 = 1'b1;
        case (f3)
          3'b000: dec.opc = ALU_ADD;
          3'b010: dec.opc = ALU_SLT;
          3'b011: dec.opc = ALU_SLTU;
          3'b100: dec.opc = ALU_XOR;
          3'b110: dec.opc = ALU_OR;
          3'b111: dec.opc = ALU_AND;
          3'b001: begin
            dec.opc = ALU_SLL;
            if (f7 != F7_BASE) dec.illegal = 1'b1;
          end
          default: begin
            if (f7 == F7_BASE)     dec.opc = ALU_SRL;
            else if (f7 == F7_ALT) dec.opc = ALU_SRA;
            else                   dec.illegal = 1'b1;
          end
        endcase
      end
      OPC_LUI: begin
        dec.a = 32'd0;
        dec.b = {inst[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        dec.a = pc;
        dec.b = {inst[31:12], 12'd0};
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.uses_rs1 = 1'b0;
      dec.uses_rs2 = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage: decode, RAW hazard stall, stage-1 ALU operand regs, stage-2 writeback strobe.
module alu_issue_stage #(
  parameter bit REGFILE_WT = 1'b0
) (
  input logic               CLK,
  input logic               RST,
  alu_issue_stage_if.slave  bus
);
  import alu_issue_stage_pkg::*;

  dec_t        dec;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_hit, rs2_hit, stall, accept, issue;

  logic        s1_vld_q, s1_vld_d;
  logic [4:0]  s1_rd_q, s1_rd_d;
  logic        s2_vld_q, s2_vld_d;
  logic [4:0]  s2_rd_q, s2_rd_d;
  alu_opc_e    opc_q, opc_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [4:0]  shft_q, shft_d;
  logic        ill_q, ill_d;
  logic [31:0] ill_inst_q, ill_inst_d;

  rv32i_alu_decode u_dec (
    .inst     (bus.INST),
    .pc       (bus.INST_PC),
    .rs1_data (bus.RS1_DATA),
    .rs2_data (bus.RS2_DATA),
    .dec      (dec)
  );

  assign rs1_addr     = bus.INST[19:15];
  assign rs2_addr     = bus.INST[24:20];
  assign bus.RS1_ADDR = rs1_addr;
  assign bus.RS2_ADDR = rs2_addr;

  // hazard compare against in-flight destinations; write-through regfile hides stage 2
  always_comb begin
    rs1_hit = (rs1_addr != 5'd0) &&
              ((s1_vld_q && s1_rd_q == rs1_addr) ||
               (!REGFILE_WT && s2_vld_q && s2_rd_q == rs1_addr));
    rs2_hit = (rs2_addr != 5'd0) &&
              ((s1_vld_q && s1_rd_q == rs2_addr) ||
               (!REGFILE_WT && s2_vld_q && s2_rd_q == rs2_addr));
    stall   = bus.INST_VLD && ((dec.uses_rs1 && rs1_hit) || (dec.uses_rs2 && rs2_hit));
    bus.INST_RDY = RST && !stall;
    accept  = bus.INST_VLD && bus.INST_RDY;
    issue   = accept && !dec.illegal;
  end

  // next state: operands load only on issue, stage 2 follows stage 1 every cycle
  always_comb begin
    s1_vld_d   = issue;
    s1_rd_d    = s1_rd_q;
    opc_d      = opc_q;
    a_d        = a_q;
    b_d        = b_q;
    shft_d     = shft_q;
    s2_vld_d   = s1_vld_q;
    s2_rd_d    = s1_rd_q;
    ill_d      = accept && dec.illegal;
    ill_inst_d = ill_inst_q;
    if (issue) begin
      s1_rd_d = dec.rd;
      opc_d   = dec.opc;
      a_d     = dec.a;
      b_d     = dec.b;
      shft_d  = dec.shft;
    end
    if (ill_d) ill_inst_d = bus.INST;
  end

  // pipeline registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      s1_vld_q   <= 1'b0;
      s1_rd_q    <= 5'd0;
      s2_vld_q   <= 1'b0;
      s2_rd_q    <= 5'd0;
      opc_q      <= ALU_ADD;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      shft_q     <= 5'd0;
      ill_q      <= 1'b0;
      ill_inst_q <= 32'd0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_rd_q    <= s1_rd_d;
      s2_vld_q   <= s2_vld_d;
      s2_rd_q    <= s2_rd_d;
      opc_q      <= opc_d;
      a_q        <= a_d;
      b_q        <= b_d;
      shft_q     <= shft_d;
      ill_q      <= ill_d;
      ill_inst_q <= ill_inst_d;
    end
  end

  assign bus.ALU_EN   = s1_vld_q;
  assign bus.ALU_A    = a_q;
  assign bus.ALU_B    = b_q;
  assign bus.ALU_OPC  = opc_q;
  assign bus.ALU_SHFT = shft_q;
  assign bus.ALU_CIN  = 1'b0;
  assign bus.WB_EN    = s2_vld_q;
  assign bus.WB_ADDR  = s2_rd_q;
  assign bus.ILLEGAL  = ill_q;
  assign bus.ILL_INST = ill_inst_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: two instances (REGFILE_WT=0 and 1) driven one at a time.
module tb_alu_issue_stage;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
    logic        legal;
    logic        u1;
    logic        u2;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shft;
  } insn_t;

  typedef struct packed {
    logic       rst;
    logic       acc;
    logic       legal;
    logic [4:0] rd;
  } hist_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vld [2];
  logic [31:0] inst_w [2];
  logic [31:0] pc_w [2];
  logic [31:0] rf [32];
  bit          sel;

  int errors = 0;
  int checks = 0;

  hist_t       h1, h2;
  logic [31:0] m_a, m_b, m_ill_inst;
  logic [4:0]  m_opc, m_shft;

  always #5 clk = ~clk;

  alu_issue_stage_if bus0 ();
  alu_issue_stage_if bus1 ();

  assign bus0.INST     = inst_w[0];
  assign bus0.INST_PC  = pc_w[0];
  assign bus0.INST_VLD = vld[0];
  assign bus0.RS1_DATA = rf[bus0.RS1_ADDR];
  assign bus0.RS2_DATA = rf[bus0.RS2_ADDR];
  assign bus1.INST     = inst_w[1];
  assign bus1.INST_PC  = pc_w[1];
  assign bus1.INST_VLD = vld[1];
  assign bus1.RS1_DATA = rf[bus1.RS1_ADDR];
  assign bus1.RS2_DATA = rf[bus1.RS2_ADDR];

  alu_issue_stage #(.REGFILE_WT(1'b0)) dut0 (.CLK(clk), .RST(rst_n), .bus(bus0));
  alu_issue_stage #(.REGFILE_WT(1'b1)) dut1 (.CLK(clk), .RST(rst_n), .bus(bus1));

  logic        o_rdy, o_en, o_cin, o_wb, o_ill;
  logic [4:0]  o_rs1, o_rs2, o_opc, o_shft, o_wb_addr;
  logic [31:0] o_a, o_b, o_ill_inst;

  assign o_rdy      = sel ? bus1.INST_RDY : bus0.INST_RDY;
  assign o_rs1      = sel ? bus1.RS1_ADDR : bus0.RS1_ADDR;
  assign o_rs2      = sel ? bus1.RS2_ADDR : bus0.RS2_ADDR;
  assign o_en       = sel ? bus1.ALU_EN   : bus0.ALU_EN;
  assign o_a        = sel ? bus1.ALU_A    : bus0.ALU_A;
  assign o_b        = sel ? bus1.ALU_B    : bus0.ALU_B;
  assign o_opc      = sel ? bus1.ALU_OPC  : bus0.ALU_OPC;
  assign o_shft     = sel ? bus1.ALU_SHFT : bus0.ALU_SHFT;
  assign o_cin      = sel ? bus1.ALU_CIN  : bus0.ALU_CIN;
  assign o_wb       = sel ? bus1.WB_EN    : bus0.WB_EN;
  assign o_wb_addr  = sel ? bus1.WB_ADDR  : bus0.WB_ADDR;
  assign o_ill      = sel ? bus1.ILLEGAL  : bus0.ILLEGAL;
  assign o_ill_inst = sel ? bus1.ILL_INST : bus0.ILL_INST;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t sel=%0d)", tag, got, exp, $time, sel);
    end
  endtask

  // A source is busy if an accepted legal instruction one cycle ago (still in stage 1)
  // or, without write-through, two cycles ago (in writeback, not flushed by reset) wrote it.
  function automatic bit busy(input bit u, input logic [4:0] rs);
    if (!u || rs == 5'd0) return 1'b0;
    if (h1.acc && h1.legal && h1.rd == rs) return 1'b1;
    if (sel == 1'b0 && h1.rst && h2.acc && h2.legal && h2.rd == rs) return 1'b1;
    return 1'b0;
  endfunction

  function automatic insn_t lit(input logic [31:0] w, input logic [31:0] pc, input bit legal,
                                input bit u1, input bit u2, input logic [4:0] opc,
                                input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    insn_t x;
    x.word = w;     x.pc = pc;   x.legal = legal; x.u1 = u1; x.u2 = u2;
    x.rd = w[11:7]; x.rs1 = w[19:15]; x.rs2 = w[24:20];
    x.opc = opc;    x.a = a;     x.b = b;         x.shft = sh;
    return x;
  endfunction

  // Encode an instruction from a mnemonic index and attach what the ALU must receive.
  function automatic insn_t mk(input int k, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [11:0] imm,
                               input logic [19:0] up, input logic [31:0] pc);
    insn_t x;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] opc;
    logic [11:0] im;
    logic [31:0] r2;
    r2 = rf[rs2];
    x = '0;
    x.pc = pc; x.legal = 1'b1; x.a = rf[rs1];
    f7 = 7'h00; f3 = 3'd0; opc = 5'd0; im = imm;
    if (k <= 9) begin
      case (k)
        0: begin f3 = 3'd0; opc = 5'd0; end
        1: begin f3 = 3'd0; opc = 5'd1; f7 = 7'h20; end
        2: begin f3 = 3'd1; opc = 5'd5; end
        3: begin f3 = 3'd2; opc = 5'd8; end
        4: begin f3 = 3'd3; opc = 5'd9; end
        5: begin f3 = 3'd4; opc = 5'd4; end
        6: begin f3 = 3'd5; opc = 5'd6; end
        7: begin f3 = 3'd5; opc = 5'd7; f7 = 7'h20; end
        8: begin f3 = 3'd6; opc = 5'd3; end
        default: begin f3 = 3'd7; opc = 5'd2; end
      endcase
      x.word = {f7, rs2, rs1, f3, rd, 7'b0110011};
      x.u1 = 1'b1; x.u2 = 1'b1; x.b = r2; x.shft = r2[4:0];
    end else if (k <= 18) begin
      case (k)
        10: begin f3 = 3'd0; opc = 5'd0; end
        11: begin f3 = 3'd2; opc = 5'd8; end
        12: begin f3 = 3'd3; opc = 5'd9; end
        13: begin f3 = 3'd4; opc = 5'd4; end
        14: begin f3 = 3'd6; opc = 5'd3; end
        15: begin f3 = 3'd7; opc = 5'd2; end
        16: begin f3 = 3'd1; opc = 5'd5; im = {7'h00, rs2}; end
        17: begin f3 = 3'd5; opc = 5'd6; im = {7'h00, rs2}; end
        default: begin f3 = 3'd5; opc = 5'd7; im = {7'h20, rs2}; end
      endcase
      x.word = {im, rs1, f3, rd, 7'b0010011};
      x.u1 = 1'b1;
      x.b = {{20{im[11]}}, im};
      x.shft = im[4:0];
    end else if (k == 19 || k == 20) begin
      x.word = {up, rd, (k == 19) ? 7'b0110111 : 7'b0010111};
      x.a = (k == 19) ? 32'd0 : pc;
      x.b = {up, 12'd0};
      x.shft = up[12:8];
    end else begin
      x.legal = 1'b0;
      if (k == 21)      x.word = {imm, rs1, 3'd0, rd, 7'b1100011};
      else if (k == 22) x.word = {7'h01, rs2, rs1, imm[2:0], rd, 7'b0110011};
      else              x.word = {7'h20, rs2, rs1, 3'b001, rd, 7'b0010011};
    end
    x.opc = opc;
    x.rd = x.word[11:7]; x.rs1 = x.word[19:15]; x.rs2 = x.word[24:20];
    return x;
  endfunction

  // One cycle: drive at posedge+1, check at negedge against the timeline model, advance it.
  task automatic tick(input insn_t x, input bit v, input bit r, output bit acc);
    bit e_rdy, e_en, e_wb, e_ill;
    rst_n = r; vld[sel] = v; inst_w[sel] = x.word; pc_w[sel] = x.pc;
    @(negedge clk);
    e_rdy = r && !(v && x.legal && (busy(x.u1, x.rs1) || busy(x.u2, x.rs2)));
    e_en  = h1.acc && h1.legal;
    e_wb  = h1.rst && h2.acc && h2.legal;
    e_ill = h1.acc && !h1.legal;
    chk("inst_rdy", o_rdy, e_rdy);
    if (v) begin
      chk("rs1_addr", o_rs1, x.rs1);
      chk("rs2_addr", o_rs2, x.rs2);
    end
    chk("alu_en", o_en, e_en);
    chk("alu_a", o_a, m_a);
    chk("alu_b", o_b, m_b);
    chk("alu_opc", o_opc, m_opc);
    chk("alu_shft", o_shft, m_shft);
    chk("alu_cin", o_cin, 1'b0);
    chk("wb_en", o_wb, e_wb);
    if (e_wb)        chk("wb_addr", o_wb_addr, h2.rd);
    else if (!h1.rst) chk("wb_addr_rst", o_wb_addr, 5'd0);
    chk("illegal", o_ill, e_ill);
    chk("ill_inst", o_ill_inst, m_ill_inst);
    acc = v && e_rdy;
    h2 = h1;
    h1.rst = r; h1.acc = acc; h1.legal = x.legal; h1.rd = x.rd;
    if (!r) begin
      m_a = '0; m_b = '0; m_opc = '0; m_shft = '0; m_ill_inst = '0;
    end else if (acc && x.legal) begin
      m_a = x.a; m_b = x.b; m_opc = x.opc; m_shft = x.shft;
    end else if (acc) begin
      m_ill_inst = x.word;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input insn_t x, output int stalls);
    bit acc;
    acc = 1'b0;
    stalls = 0;
    for (int k = 0; k < 8 && !acc; k++) begin
      tick(x, 1'b1, 1'b1, acc);
      if (!acc) stalls++;
    end
    chk("send_accept", acc, 1'b1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) tick('0, 1'b0, 1'b1, acc);
  endtask

  task automatic hard_reset();
    rst_n = 1'b0;
    vld[0] = 1'b0; vld[1] = 1'b0;
    inst_w[0] = '0; inst_w[1] = '0; pc_w[0] = '0; pc_w[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    h1 = '0; h2 = '0;
    m_a = '0; m_b = '0; m_opc = '0; m_shft = '0; m_ill_inst = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    insn_t add3, add4, srai, lui, auipc, addi, beq, x;
    int st;
    bit acc;

    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'd0; rf[1] = 32'd5; rf[2] = 32'd7; rf[3] = 32'h33; rf[6] = 32'h8000_0000;

    add3  = lit(32'h002081B3, 32'h0,   1, 1, 1, 5'd0, 32'd5,        32'd7,        5'd7);
    add4  = lit(32'h00208233, 32'h0,   1, 1, 1, 5'd0, 32'd5,        32'd7,        5'd7);
    srai  = lit(32'h40435293, 32'h0,   1, 1, 0, 5'd7, 32'h8000_0000, 32'h0000_0404, 5'd4);
    lui   = lit(32'h123453B7, 32'h0,   1, 0, 0, 5'd0, 32'd0,        32'h1234_5000, 5'd3);
    auipc = lit(32'h12345397, 32'h100, 1, 0, 0, 5'd0, 32'h100,      32'h1234_5000, 5'd3);
    addi  = lit(32'h00118213, 32'h0,   1, 1, 0, 5'd0, 32'h33,       32'd1,        5'd1);
    beq   = lit(32'h00000063, 32'h0,   0, 0, 0, 5'd0, 32'd0,        32'd0,        5'd0);

    sel = 1'b0;
    hard_reset();
    tick('0, 1'b0, 1'b0, acc);

    send(add3, st);  idle(3);
    send(srai, st);  send(lui, st);  send(auipc, st);  idle(3);

    send(add3, st);  send(addi, st);
    chk("raw_stall_wt0", st, 2);
    idle(3);

    send(beq, st);   send(add3, st);
    chk("stall_after_illegal", st, 0);
    idle(3);

    send(add3, st);  send(add4, st);
    tick(add3, 1'b1, 1'b0, acc);
    idle(3);
    send(add3, st);
    chk("stall_after_reset", st, 0);
    idle(3);

    sel = 1'b1;
    hard_reset();
    send(add3, st);  send(addi, st);
    chk("raw_stall_wt1", st, 1);
    idle(3);

    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      hard_reset();
      for (int i = 0; i < 250; i++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        if ($urandom_range(0, 59) == 0) tick('0, 1'b0, 1'b0, acc);
        x = mk($urandom_range(0, 23), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
               5'($urandom_range(0, 5)), 12'($urandom), 20'($urandom), {$urandom, 2'b00} >> 2 << 2);
        send(x, st);
      end
      idle(3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
